// File: rtl/serial_adder_ctrl.sv
// Bit-serial adder sequencer driving one external 1-bit full adder through the fa_* ports.
// Define SERIAL_ADDER_OVF_EN to add the ovf_out signed-overflow flag.
module serial_adder_ctrl #(
   parameter int WIDTH = 8
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             start_valid,
   output logic             start_ready,
   input  logic [WIDTH-1:0] a_in,
   input  logic [WIDTH-1:0] b_in,
   input  logic             c_in,
   output logic             fa_a_out,
   output logic             fa_b_out,
   output logic             fa_c_out,
   input  logic             fa_sum_in,
   input  logic             fa_cout_in,
   output logic [WIDTH-1:0] sum_out,
   output logic             c_out,
`ifdef SERIAL_ADDER_OVF_EN
   output logic             ovf_out,
`endif
   output logic             done_valid,
   input  logic             done_ready
);

   localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
   localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      RUN  = 2'd1,
      DONE = 2'd2
   } state_t;

   state_t          state;
   state_t          state_next;
   logic [WIDTH-1:0] a_sh;
   logic [WIDTH-1:0] b_sh;
   logic [WIDTH-1:0] sum_sh;
   logic             carry;
   logic [CW-1:0]    cnt;

   always_ff @(posedge clk) begin
      if (reset) state <= IDLE;
      else       state <= state_next;
   end

   always_comb begin
      state_next  = state;
      start_ready = 1'b0;
      done_valid  = 1'b0;
      fa_a_out    = 1'b0;
      fa_b_out    = 1'b0;
      fa_c_out    = 1'b0;
      case (state)
         IDLE: begin
            start_ready = 1'b1;
            if (start_valid) state_next = RUN;
         end
         RUN: begin
            fa_a_out = a_sh[0];
            fa_b_out = b_sh[0];
            fa_c_out = carry;
            if (cnt == LAST) state_next = DONE;
         end
         DONE: begin
            done_valid = 1'b1;
            if (done_ready) state_next = IDLE;
         end
         default: state_next = IDLE;
      endcase
   end

   // Sum bits enter at the MSB so after WIDTH shifts bit 0 of the result sits at the LSB.
   always_ff @(posedge clk) begin
      if (reset) begin
         a_sh    <= '0;
         b_sh    <= '0;
         sum_sh  <= '0;
         carry   <= 1'b0;
         cnt     <= '0;
         c_out   <= 1'b0;
`ifdef SERIAL_ADDER_OVF_EN
         ovf_out <= 1'b0;
`endif
      end else begin
         case (state)
            IDLE: begin
               if (start_valid) begin
                  a_sh  <= a_in;
                  b_sh  <= b_in;
                  carry <= c_in;
                  cnt   <= '0;
               end
            end
            RUN: begin
               a_sh   <= a_sh >> 1;
               b_sh   <= b_sh >> 1;
               sum_sh <= (sum_sh >> 1) | (WIDTH'(fa_sum_in) << (WIDTH - 1));
               carry  <= fa_cout_in;
               cnt    <= cnt + CW'(1);
               if (cnt == LAST) begin
                  c_out   <= fa_cout_in;
`ifdef SERIAL_ADDER_OVF_EN
                  ovf_out <= carry ^ fa_cout_in;
`endif
               end
            end
            default: ;
         endcase
      end
   end

   assign sum_out = sum_sh;

endmodule

// File: tb/tb_serial_adder_ctrl.sv
// Self-checking bench for serial_adder_ctrl (WIDTH=8) with a behavioural full adder beside it.
// Define SERIAL_ADDER_OVF_EN for both files to also check ovf_out.
module tb_serial_adder_ctrl;

   localparam int WIDTH = 8;

   logic             clk = 1'b0;
   logic             reset = 1'b1;
   logic             start_valid = 1'b0;
   logic             start_ready;
   logic [WIDTH-1:0] a_in = '0;
   logic [WIDTH-1:0] b_in = '0;
   logic             c_in = 1'b0;
   logic             fa_a_out, fa_b_out, fa_c_out;
   logic             fa_sum_in, fa_cout_in;
   logic [WIDTH-1:0] sum_out;
   logic             c_out;
   logic             done_valid;
   logic             done_ready = 1'b0;
`ifdef SERIAL_ADDER_OVF_EN
   logic             ovf_out;
`endif

   int total = 0;
   int bad = 0;

   always #5 clk = ~clk;

   assign fa_sum_in  = fa_a_out ^ fa_b_out ^ fa_c_out;
   assign fa_cout_in = (fa_a_out & fa_b_out) | (fa_a_out & fa_c_out) | (fa_b_out & fa_c_out);

   serial_adder_ctrl #(.WIDTH(WIDTH)) dut (
      .clk(clk),
      .reset(reset),
      .start_valid(start_valid),
      .start_ready(start_ready),
      .a_in(a_in),
      .b_in(b_in),
      .c_in(c_in),
      .fa_a_out(fa_a_out),
      .fa_b_out(fa_b_out),
      .fa_c_out(fa_c_out),
      .fa_sum_in(fa_sum_in),
      .fa_cout_in(fa_cout_in),
      .sum_out(sum_out),
      .c_out(c_out),
`ifdef SERIAL_ADDER_OVF_EN
      .ovf_out(ovf_out),
`endif
      .done_valid(done_valid),
      .done_ready(done_ready)
   );

   typedef struct {
      logic [7:0] a;
      logic [7:0] b;
      logic       c;
      logic [7:0] expSum;
      logic       expCout;
      logic       expOvf;
   } vec_t;

   task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("[TB] FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // Reference result from plain integer arithmetic: unsigned sum and signed-range overflow.
   function automatic void refModel(input logic [7:0] a, input logic [7:0] b, input logic c,
                                    output logic [7:0] s, output logic co, output logic ovf);
      int u;
      int sv;
      u   = int'(a) + int'(b) + int'(c);
      sv  = int'($signed(a)) + int'($signed(b)) + int'(c);
      s   = u[7:0];
      co  = u[8];
      ovf = (sv > 127) || (sv < -128);
   endfunction

   // Full operation: handshake in, watch the full-adder feed each RUN cycle, then collect the result.
   task automatic applyStimulus(input logic [7:0] a, input logic [7:0] b, input logic c,
                                input logic [7:0] expSum, input logic expCout, input logic expOvf,
                                input string tag);
      int lat;
      int faErr;
      int carryIn;
      int wait_cnt;
      wait_cnt = 0;
      while (!start_ready && wait_cnt < 50) begin
         tick();
         wait_cnt++;
      end
      checkOutput({tag, " start_ready"}, 32'(start_ready), 32'd1);
      start_valid = 1'b1;
      a_in = a;
      b_in = b;
      c_in = c;
      tick();
      start_valid = 1'b0;
      a_in = 8'($urandom);
      b_in = 8'($urandom);
      c_in = 1'($urandom);
      lat = 0;
      faErr = 0;
      while (!done_valid && lat < 40) begin
         if (lat < WIDTH) begin
            carryIn = ((int'(a) % (1 << lat)) + (int'(b) % (1 << lat)) + int'(c)) >> lat;
            if (fa_a_out !== a[lat] || fa_b_out !== b[lat] || fa_c_out !== carryIn[0]) faErr++;
         end
         tick();
         lat++;
      end
      checkOutput({tag, " latency"}, 32'(lat), 32'(WIDTH));
      checkOutput({tag, " fa_feed_errors"}, 32'(faErr), 32'd0);
      checkOutput({tag, " sum_out"}, 32'(sum_out), 32'(expSum));
      checkOutput({tag, " c_out"}, 32'(c_out), 32'(expCout));
`ifdef SERIAL_ADDER_OVF_EN
      checkOutput({tag, " ovf_out"}, 32'(ovf_out), 32'(expOvf));
`else
      if (expOvf === 1'bx) $display("[TB] unexpected x ovf for %s", tag);
`endif
      done_ready = 1'b1;
      tick();
      done_ready = 1'b0;
      checkOutput({tag, " idle_after_done"}, {30'd0, start_ready, done_valid}, 32'b10);
   endtask

   vec_t vecs[6];

   initial begin
      logic [7:0] rs;
      logic       rc, ro;
      logic [7:0] holdSum;
      logic       holdCout;
      int         dvCount;

      vecs[0] = '{a: 8'h00, b: 8'h00, c: 1'b0, expSum: 8'h00, expCout: 1'b0, expOvf: 1'b0};
      vecs[1] = '{a: 8'hFF, b: 8'h01, c: 1'b0, expSum: 8'h00, expCout: 1'b1, expOvf: 1'b0};
      vecs[2] = '{a: 8'h7F, b: 8'h01, c: 1'b0, expSum: 8'h80, expCout: 1'b0, expOvf: 1'b1};
      vecs[3] = '{a: 8'hA5, b: 8'h5A, c: 1'b1, expSum: 8'h00, expCout: 1'b1, expOvf: 1'b0};
      vecs[4] = '{a: 8'h80, b: 8'h80, c: 1'b0, expSum: 8'h00, expCout: 1'b1, expOvf: 1'b1};
      vecs[5] = '{a: 8'hFF, b: 8'hFF, c: 1'b1, expSum: 8'hFF, expCout: 1'b1, expOvf: 1'b0};

      reset = 1'b1;
      tick();
      tick();
      reset = 1'b0;
      checkOutput("reset start_ready", 32'(start_ready), 32'd1);
      checkOutput("reset done_valid", 32'(done_valid), 32'd0);
      checkOutput("reset sum_out", 32'(sum_out), 32'd0);
      checkOutput("reset c_out", 32'(c_out), 32'd0);
      checkOutput("reset fa_outs", {29'd0, fa_a_out, fa_b_out, fa_c_out}, 32'd0);

      for (int i = 0; i < 6; i++)
         applyStimulus(vecs[i].a, vecs[i].b, vecs[i].c, vecs[i].expSum, vecs[i].expCout,
                       vecs[i].expOvf, $sformatf("vec%0d", i));

      for (int i = 0; i < 20; i++) begin
         logic [7:0] ra, rb;
         logic       rci;
         ra  = 8'($urandom);
         rb  = 8'($urandom);
         rci = 1'($urandom);
         refModel(ra, rb, rci, rs, rc, ro);
         applyStimulus(ra, rb, rci, rs, rc, ro, $sformatf("rand%0d", i));
      end

      // Backpressure: result must hold while the sink stalls and new starts are refused.
      start_valid = 1'b1;
      a_in = 8'h3C;
      b_in = 8'h0F;
      c_in = 1'b0;
      tick();
      start_valid = 1'b0;
      dvCount = 0;
      while (!done_valid && dvCount < 40) begin
         tick();
         dvCount++;
      end
      checkOutput("bp latency", 32'(dvCount), 32'(WIDTH));
      holdSum  = sum_out;
      holdCout = c_out;
      checkOutput("bp sum", 32'(holdSum), 32'h4B);
      checkOutput("bp cout", 32'(holdCout), 32'd0);
      for (int i = 0; i < 5; i++) begin
         start_valid = 1'(i % 2 == 0);
         a_in = 8'hEE;
         b_in = 8'hDD;
         c_in = 1'b1;
         tick();
         checkOutput($sformatf("bp hold%0d", i),
                     {20'd0, start_ready, done_valid, c_out, fa_a_out | fa_b_out | fa_c_out, sum_out},
                     {20'd0, 1'b0, 1'b1, holdCout, 1'b0, holdSum});
      end
      start_valid = 1'b0;
      done_ready = 1'b1;
      tick();
      done_ready = 1'b0;
      checkOutput("bp release", {30'd0, start_ready, done_valid}, 32'b10);
      tick();
      checkOutput("bp no_stale_start", {30'd0, start_ready, done_valid}, 32'b10);

      // Reset during the third RUN cycle discards the operation.
      start_valid = 1'b1;
      a_in = 8'h12;
      b_in = 8'h34;
      c_in = 1'b0;
      tick();
      start_valid = 1'b0;
      tick();
      tick();
      reset = 1'b1;
      tick();
      reset = 1'b0;
      checkOutput("midrun reset ready", 32'(start_ready), 32'd1);
      checkOutput("midrun reset outs", {22'd0, done_valid, c_out, sum_out}, 32'd0);
      dvCount = 0;
      for (int i = 0; i < 20; i++) begin
         tick();
         if (done_valid) dvCount++;
      end
      checkOutput("midrun no_done", 32'(dvCount), 32'd0);

      applyStimulus(8'h12, 8'h34, 1'b0, 8'h46, 1'b0, 1'b0, "post_reset");

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
